// File: rtl/adder_seq_pkg.sv
// Shared types and constants for the chained-adder sequence driver.
package adder_seq_pkg;

    // Driver sequencing states; the 3-bit encoding leaves two codes unused.
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        PH0  = 3'd1,
        PH1  = 3'd2,
        PH2  = 3'd3,
        WAIT = 3'd4,
        RESP = 3'd5
    } state_t;

    // Adder phase-select codes.
    localparam logic [1:0] ENBL_LD01 = 2'd0;
    localparam logic [1:0] ENBL_LD2  = 2'd1;
    localparam logic [1:0] ENBL_LD3  = 2'd2;
    localparam logic [1:0] ENBL_IDLE = 2'd3;

    // Phase select presented to the adder while the driver sits in a state.
    function automatic logic [1:0] enbl_of(input state_t s);
        logic [1:0] e;
        case (s)
            PH0:     e = ENBL_LD01;
            PH1:     e = ENBL_LD2;
            PH2:     e = ENBL_LD3;
            default: e = ENBL_IDLE;
        endcase
        return e;
    endfunction

endpackage

// File: rtl/adder_seq_fsm.sv
// Sequencing FSM: owns the state register and result wait counter, issues
// the adder phase select and the load / capture / release strobes.
module adder_seq_fsm
    import adder_seq_pkg::*;
#(
    parameter int RES_DELAY = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_req_valid,
    input  logic       i_rsp_ready,
    output logic       o_load,
    output logic       o_capture,
    output logic       o_release,
    output logic [1:0] o_add_enbl,
    output logic       o_req_ready,
    output logic       o_busy
);

    localparam int CW = (RES_DELAY > 1) ? $clog2(RES_DELAY) : 1;

    state_t          r_state;
    state_t          w_next;
    logic [CW-1:0]   r_cnt;
    logic [CW-1:0]   w_cnt_next;
    logic [1:0]      r_add_enbl;
    logic            r_req_ready;
    logic            r_busy;

    // Next-state, wait-counter and strobe decode for the current state.
    always_comb begin
        w_next     = r_state;
        w_cnt_next = r_cnt;
        o_load     = 1'b0;
        o_capture  = 1'b0;
        o_release  = 1'b0;
        case (r_state)
            IDLE: begin
                if (i_req_valid && r_req_ready) begin
                    o_load = 1'b1;
                    w_next = PH0;
                end else begin
                    w_next = IDLE;
                end
            end
            PH0: w_next = PH1;
            PH1: w_next = PH2;
            PH2: begin
                w_cnt_next = CW'(RES_DELAY - 1);
                w_next     = WAIT;
            end
            WAIT: begin
                if (r_cnt == CW'(0)) begin
                    o_capture = 1'b1;
                    w_next    = RESP;
                end else begin
                    w_cnt_next = r_cnt - CW'(1);
                end
            end
            RESP: begin
                if (i_rsp_ready) begin
                    o_release = 1'b1;
                    w_next    = IDLE;
                end else begin
                    w_next = RESP;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    // State, counter and registered control outputs derived from the next state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= IDLE;
            r_cnt       <= CW'(0);
            r_add_enbl  <= ENBL_IDLE;
            r_req_ready <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_next;
            r_cnt       <= w_cnt_next;
            r_add_enbl  <= enbl_of(w_next);
            r_req_ready <= (w_next == IDLE);
            r_busy      <= (w_next != IDLE);
        end
    end

    assign o_add_enbl  = r_add_enbl;
    assign o_req_ready = r_req_ready;
    assign o_busy      = r_busy;

endmodule

// File: rtl/adder_seq_driver.sv
// Initiator for the three-stage chained adder: accepts a four-operand
// request, steps the adder phases, captures and self-checks the sum, and
// returns it on a valid/ready response channel with op/error counters.
module adder_seq_driver
    import adder_seq_pkg::*;
#(
    parameter int W         = 8,
    parameter int RES_DELAY = 2,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [W-1:0]     req_a,
    input  logic [W-1:0]     req_b,
    input  logic [W-1:0]     req_c,
    input  logic [W-1:0]     req_d,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [W-1:0]     rsp_sum,
    output logic             rsp_err,
    output logic [W-1:0]     add_in1,
    output logic [W-1:0]     add_in2,
    output logic [W-1:0]     add_in3,
    output logic [W-1:0]     add_in4,
    output logic [1:0]       add_enbl,
    input  logic [W-1:0]     add_out,
    output logic [CNT_W-1:0] ops_done,
    output logic [CNT_W-1:0] err_cnt,
    output logic             busy
);

    logic             w_load;
    logic             w_capture;
    logic             w_release;
    logic [W-1:0]     r_add_in1;
    logic [W-1:0]     r_add_in2;
    logic [W-1:0]     r_add_in3;
    logic [W-1:0]     r_add_in4;
    logic [W-1:0]     r_ref;
    logic [W-1:0]     r_rsp_sum;
    logic             r_rsp_err;
    logic             r_rsp_valid;
    logic [CNT_W-1:0] r_ops_done;
    logic [CNT_W-1:0] r_err_cnt;

    adder_seq_fsm #(
        .RES_DELAY (RES_DELAY)
    ) u_fsm (
        .clk         (clk),
        .rst         (rst),
        .i_req_valid (req_valid),
        .i_rsp_ready (rsp_ready),
        .o_load      (w_load),
        .o_capture   (w_capture),
        .o_release   (w_release),
        .o_add_enbl  (add_enbl),
        .o_req_ready (req_ready),
        .o_busy      (busy)
    );

    // Operands and the modulo-2^W reference are latched at acceptance and
    // held until the next acceptance.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_add_in1 <= '0;
            r_add_in2 <= '0;
            r_add_in3 <= '0;
            r_add_in4 <= '0;
            r_ref     <= '0;
        end else if (w_load) begin
            r_add_in1 <= req_a;
            r_add_in2 <= req_b;
            r_add_in3 <= req_c;
            r_add_in4 <= req_d;
            r_ref     <= req_a + req_b + req_c + req_d;
        end
    end

    // Response capture and handshake; sum and error stay frozen while valid.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rsp_sum   <= '0;
            r_rsp_err   <= 1'b0;
            r_rsp_valid <= 1'b0;
        end else if (w_capture) begin
            r_rsp_sum   <= add_out;
            r_rsp_err   <= (add_out != r_ref);
            r_rsp_valid <= 1'b1;
        end else if (w_release) begin
            r_rsp_valid <= 1'b0;
        end
    end

    // Completed-op counter wraps; error counter saturates at all-ones.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ops_done <= '0;
            r_err_cnt  <= '0;
        end else if (w_release) begin
            r_ops_done <= r_ops_done + CNT_W'(1);
            if (r_rsp_err && (r_err_cnt != {CNT_W{1'b1}})) begin
                r_err_cnt <= r_err_cnt + CNT_W'(1);
            end
        end
    end

    assign add_in1   = r_add_in1;
    assign add_in2   = r_add_in2;
    assign add_in3   = r_add_in3;
    assign add_in4   = r_add_in4;
    assign rsp_sum   = r_rsp_sum;
    assign rsp_err   = r_rsp_err;
    assign rsp_valid = r_rsp_valid;
    assign ops_done  = r_ops_done;
    assign err_cnt   = r_err_cnt;

endmodule

// File: tb/tb_adder_seq_driver.sv
// Bench for adder_seq_driver: a behavioural three-stage adder drives add_out,
// a transaction-level model predicts every output each cycle, and directed
// plus randomized requests exercise handshake, wrap, mismatch, backpressure,
// mid-operation reset and counter wrap/saturation (second instance, CNT_W=2).
module tb_adder_seq_driver;

    localparam int RD = 2;

    logic       clk;
    logic       rst;
    logic       req_valid;
    logic       rsp_ready;
    logic [7:0] req_a, req_b, req_c, req_d;
    logic       force_zero;

    logic        req_ready, rsp_valid, rsp_err, busy;
    logic [7:0]  rsp_sum, add_in1, add_in2, add_in3, add_in4, add_out;
    logic [1:0]  add_enbl;
    logic [15:0] ops_done, err_cnt;

    logic        req_ready_s, rsp_valid_s, rsp_err_s, busy_s;
    logic [7:0]  rsp_sum_s, add_in1_s, add_in2_s, add_in3_s, add_in4_s;
    logic [1:0]  add_enbl_s;
    logic [1:0]  ops_done_s, err_cnt_s;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    bit cmp_en = 1'b0;

    adder_seq_driver #(.W(8), .RES_DELAY(RD), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_c(req_c), .req_d(req_d),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_sum(rsp_sum), .rsp_err(rsp_err),
        .add_in1(add_in1), .add_in2(add_in2), .add_in3(add_in3), .add_in4(add_in4),
        .add_enbl(add_enbl), .add_out(add_out), .ops_done(ops_done), .err_cnt(err_cnt),
        .busy(busy)
    );

    adder_seq_driver #(.W(8), .RES_DELAY(RD), .CNT_W(2)) dut_s (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready_s),
        .req_a(req_a), .req_b(req_b), .req_c(req_c), .req_d(req_d),
        .rsp_valid(rsp_valid_s), .rsp_ready(rsp_ready), .rsp_sum(rsp_sum_s), .rsp_err(rsp_err_s),
        .add_in1(add_in1_s), .add_in2(add_in2_s), .add_in3(add_in3_s), .add_in4(add_in4_s),
        .add_enbl(add_enbl_s), .add_out(add_out), .ops_done(ops_done_s), .err_cnt(err_cnt_s),
        .busy(busy_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural chained adder: in1+in2, then +in3, then +in4 into the output register.
    logic [7:0] a_s1 = 8'd0, a_s2 = 8'd0, a_q = 8'd0;
    always @(posedge clk) begin
        case (add_enbl)
            2'd0:    a_s1 <= add_in1 + add_in2;
            2'd1:    a_s2 <= a_s1 + add_in3;
            2'd2:    a_q  <= a_s2 + add_in4;
            default: a_q  <= a_q;
        endcase
    end
    assign add_out = force_zero ? 8'd0 : a_q;

    // Transaction-level model: age of the in-flight request decides phase and response.
    bit          m_active, m_resp, m_ready, m_force, m_err;
    int          m_k;
    logic [7:0]  m_in [4];
    logic [7:0]  m_ref, m_sum;
    int unsigned m_ops, m_errs;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_active <= 1'b0; m_resp <= 1'b0; m_ready <= 1'b0; m_force <= 1'b0;
            m_err <= 1'b0; m_k <= 0; m_ref <= 8'd0; m_sum <= 8'd0;
            m_ops <= 0; m_errs <= 0;
            for (int i = 0; i < 4; i++) m_in[i] <= 8'd0;
        end else if (m_resp) begin
            if (rsp_ready) begin
                m_resp <= 1'b0; m_active <= 1'b0; m_ready <= 1'b1;
                m_ops <= m_ops + 1;
                if (m_err) m_errs <= m_errs + 1;
            end
        end else if (m_active) begin
            m_k <= m_k + 1;
            if (m_k + 1 == 3 + RD) begin
                m_resp <= 1'b1;
                m_sum  <= m_force ? 8'd0 : m_ref;
                m_err  <= m_force && (m_ref != 8'd0);
            end
        end else if (req_valid && m_ready) begin
            m_active <= 1'b1; m_ready <= 1'b0; m_k <= 0; m_force <= force_zero;
            m_in[0] <= req_a; m_in[1] <= req_b; m_in[2] <= req_c; m_in[3] <= req_d;
            m_ref <= 8'((int'(req_a) + int'(req_b) + int'(req_c) + int'(req_d)) % 256);
        end else begin
            m_ready <= 1'b1;
        end
    end

    function automatic int exp_enbl();
        if (!m_active || m_resp) return 3;
        else if (m_k <= 2) return m_k;
        else return 3;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic tmo(input string nm);
        checks++;
        errors++;
        $display("FAIL %s: timed out waiting, required event never seen (t=%0t)", nm, $time);
    endtask

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        if (cmp_en) begin
            chk("req_ready", 32'(req_ready), 32'(m_ready));
            chk("busy",      32'(busy),      32'(m_active));
            chk("add_enbl",  32'(add_enbl),  32'(exp_enbl()));
            chk("rsp_valid", 32'(rsp_valid), 32'(m_resp));
            chk("rsp_sum",   32'(rsp_sum),   32'(m_sum));
            chk("rsp_err",   32'(rsp_err),   32'(m_err));
            chk("add_in1",   32'(add_in1),   32'(m_in[0]));
            chk("add_in2",   32'(add_in2),   32'(m_in[1]));
            chk("add_in3",   32'(add_in3),   32'(m_in[2]));
            chk("add_in4",   32'(add_in4),   32'(m_in[3]));
            chk("ops_done",  32'(ops_done),  m_ops & 32'hFFFF);
            chk("err_cnt",   32'(err_cnt),   (m_errs > 32'd65535) ? 32'd65535 : m_errs);
            chk("ops_done_s", 32'(ops_done_s), m_ops & 32'h3);
            chk("err_cnt_s",  32'(err_cnt_s),  (m_errs > 32'd3) ? 32'd3 : m_errs);
            chk("rsp_valid_s", 32'(rsp_valid_s), 32'(m_resp));
        end
    end

    // Present a request; returns at the negedge after the accepting edge.
    task automatic send(input logic [7:0] a, b, c, d, output int acc);
        req_a = a; req_b = b; req_c = c; req_d = d; req_valid = 1'b1;
        acc = -1;
        for (int i = 0; i < 300; i++) begin
            if (m_ready) begin acc = cyc + 1; break; end
            @(negedge clk);
        end
        if (acc < 0) tmo("accept");
        @(negedge clk);
        req_valid = 1'b0;
        req_a = 8'($urandom); req_b = 8'($urandom); req_c = 8'($urandom); req_d = 8'($urandom);
    endtask

    task automatic wait_idle(input bit rnd);
        for (int i = 0; i < 300; i++) begin
            if (!m_active) break;
            if (rnd) rsp_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
        end
        if (m_active) tmo("idle");
        rsp_ready = 1'b1;
    endtask

    task automatic run_op(input logic [7:0] a, b, c, d, input logic [7:0] es, input bit ee,
                          input string nm);
        int acc, seen;
        send(a, b, c, d, acc);
        seen = -1;
        for (int i = 0; i < 50; i++) begin
            if (rsp_valid === 1'b1) begin seen = cyc; break; end
            @(negedge clk);
        end
        if (seen < 0) tmo({nm, "_rsp"});
        else begin
            chk({nm, "_latency"}, 32'(seen - acc), 32'd5);
            chk({nm, "_sum"}, 32'(rsp_sum), 32'(es));
            chk({nm, "_err"}, 32'(rsp_err), 32'(ee));
        end
        wait_idle(1'b0);
    endtask

    initial begin
        int acc;
        logic [7:0] ra, rb, rc, rd;
        rst = 1'b1; req_valid = 1'b0; rsp_ready = 1'b1; force_zero = 1'b0;
        req_a = 8'd0; req_b = 8'd0; req_c = 8'd0; req_d = 8'd0;
        #1 rst = 1'b0;
        cmp_en = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_enbl",  32'(add_enbl),  32'd3);
        chk("rst_ready", 32'(req_ready), 32'd0);
        chk("rst_valid", 32'(rsp_valid), 32'd0);
        chk("rst_busy",  32'(busy),      32'd0);
        #2 rst = 1'b1;
        @(negedge clk);
        chk("ready_after_rst", 32'(req_ready), 32'd1);

        run_op(8'd10, 8'd20, 8'd30, 8'd40, 8'd100, 1'b0, "basic");
        chk("basic_ops", 32'(ops_done), 32'd1);
        run_op(8'd200, 8'd100, 8'd0, 8'd1, 8'd45, 1'b0, "wrap");
        force_zero = 1'b1;
        run_op(8'd1, 8'd1, 8'd1, 8'd1, 8'd0, 1'b1, "force");
        force_zero = 1'b0;
        chk("force_errcnt", 32'(err_cnt), 32'd1);

        // Backpressure with a competing request while busy.
        rsp_ready = 1'b0;
        send(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), acc);
        for (int i = 0; i < 50; i++) begin
            if (m_resp) break;
            @(negedge clk);
        end
        if (!m_resp) tmo("bp_rsp");
        req_valid = 1'b1;
        req_a = 8'd9; req_b = 8'd8; req_c = 8'd7; req_d = 8'd6;
        for (int i = 0; i < 10; i++) begin
            chk("bp_enbl",  32'(add_enbl),  32'd3);
            chk("bp_ready", 32'(req_ready), 32'd0);
            chk("bp_valid", 32'(rsp_valid), 32'd1);
            @(negedge clk);
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        wait_idle(1'b0);

        // Reset during PH1.
        send(8'd1, 8'd2, 8'd3, 8'd4, acc);
        @(negedge clk);
        chk("mid_enbl", 32'(add_enbl), 32'd1);
        #2 rst = 1'b0;
        #1;
        chk("mid_rst_enbl",  32'(add_enbl),  32'd3);
        chk("mid_rst_busy",  32'(busy),      32'd0);
        chk("mid_rst_ready", 32'(req_ready), 32'd0);
        chk("mid_rst_valid", 32'(rsp_valid), 32'd0);
        chk("mid_rst_in1",   32'(add_in1),   32'd0);
        chk("mid_rst_ops",   32'(ops_done),  32'd0);
        chk("mid_rst_errs",  32'(err_cnt),   32'd0);
        @(negedge clk);
        #2 rst = 1'b1;
        @(negedge clk);
        run_op(8'd5, 8'd5, 8'd5, 8'd5, 8'd20, 1'b0, "post_rst");
        chk("post_rst_ops", 32'(ops_done), 32'd1);

        // Back-to-back requests.
        for (int k = 0; k < 3; k++) begin
            ra = 8'($urandom); rb = 8'($urandom); rc = 8'($urandom); rd = 8'($urandom);
            run_op(ra, rb, rc, rd, 8'((int'(ra) + int'(rb) + int'(rc) + int'(rd)) % 256), 1'b0, "b2b");
        end
        chk("b2b_ops", 32'(ops_done), 32'd4);

        // Randomized traffic with random backpressure and injected mismatches.
        for (int i = 0; i < 40; i++) begin
            force_zero = (i % 5 == 0) || ($urandom_range(0, 7) == 0);
            if (force_zero) begin
                ra = 8'($urandom_range(1, 255)); rb = 8'd0; rc = 8'd0; rd = 8'd0;
            end else begin
                ra = 8'($urandom); rb = 8'($urandom); rc = 8'($urandom); rd = 8'($urandom);
            end
            send(ra, rb, rc, rd, acc);
            wait_idle(1'b1);
            force_zero = 1'b0;
            if (i == 0) chk("small_ops_wrap", 32'(ops_done_s), 32'd1);
        end
        @(negedge clk);
        chk("final_ops",     32'(ops_done),   32'd44);
        chk("final_ops_s",   32'(ops_done_s), 32'd0);
        chk("final_errsat_s", 32'(err_cnt_s), 32'd3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/adder_seq_driver.md
Name: adder_seq_driver

Overview:
- Initiator for the three-stage 8-bit chained adder (in1..in4, enbl phase select, registered out).
- Accepts a four-operand request on a valid/ready handshake and drives the adder phases enbl=0,1,2 in order.
- Waits the fixed adder latency, captures the sum and returns it on a valid/ready response channel.
- Self-checks the captured sum against an internal modulo-2^W reference and counts completed operations and mismatches.

Parameters:
- W, 8, operand/sum width; must match the adder datapath.
- RES_DELAY, 2, wait cycles after the enbl=2 cycle before add_out is sampled; minimum 1.
- CNT_W, 16, width of the op and error counters.

Ports:
- clk  input  1  clock
- rst  input  1  reset, asynchronous, active-low
- req_valid  input  1  request operands valid
- req_ready  output  1  driver can accept a request
- req_a, req_b, req_c, req_d  input  W each  operands
- rsp_valid  output  1  response valid
- rsp_ready  input  1  consumer accepts response
- rsp_sum  output  W  captured adder result
- rsp_err  output  1  captured result differs from the internal reference
- add_in1, add_in2, add_in3, add_in4  output  W each  adder operand inputs
- add_enbl  output  2  adder phase select; 3 = idle/hold
- add_out  input  W  adder registered result
- ops_done  output  CNT_W  completed responses, wraps
- err_cnt  output  CNT_W  responses with rsp_err=1, saturates at all-ones
- busy  output  1  high in any state except IDLE

Behaviour:
- Reset (rst=0, async): state IDLE; all outputs 0 except add_enbl=3; req_ready=1 only after reset is released. Reset mid-operation aborts it; no response is produced.
- FSM states: IDLE, PH0, PH1, PH2, WAIT, RESP.
- IDLE: req_ready=1 and add_enbl=3. On req_valid&req_ready:
  - latch the four operands into add_in1..4;
  - latch ref = a+b+c+d mod 2^W;
  - go to PH0.
- PH0: add_enbl=0. Next state PH1.
- PH1: add_enbl=1. Next state PH2.
- PH2: add_enbl=2. Load the wait counter with RES_DELAY-1. Next state WAIT.
- WAIT: add_enbl=3. Count down. When the counter is 0:
  - rsp_sum <= add_out;
  - rsp_err <= (add_out != ref);
  - rsp_valid <= 1;
  - go to RESP.
- RESP: add_enbl=3. Hold rsp_sum and rsp_err stable while rsp_valid=1. On rsp_valid&rsp_ready:
  - rsp_valid <= 0;
  - ops_done += 1;
  - err_cnt += rsp_err (saturating);
  - go to IDLE.
- Back-to-back: a new request is accepted in the IDLE cycle following the response handshake (no bypass).
- Operand stability: add_in1..4 are held from acceptance until the next acceptance; they never change during PH0..WAIT.
- Latency: acceptance edge to rsp_valid high is 3+RES_DELAY cycles; with default RES_DELAY=2 this is 5 cycles.
- rsp_ready held low: the block remains in RESP indefinitely and req_ready stays 0.
- Arithmetic: all sums are modulo 2^W; carry-out is discarded in both the adder and the reference.
- Counters: ops_done wraps from all-ones to 0; err_cnt saturates at all-ones.
- Unknown/unused state encodings: recover to IDLE with add_enbl=3.

Decomposition:
- Shared package adder_seq_pkg:
  - state enum (IDLE, PH0, PH1, PH2, WAIT, RESP);
  - enbl constants ENBL_LD01=0, ENBL_LD2=1, ENBL_LD3=2, ENBL_IDLE=3.
- Submodule adder_seq_fsm:
  - owns the state register and wait counter;
  - emits add_enbl and load/capture strobes.
- Datapath registers, reference sum and counters stay in the top module.

Test Plan:
- Basic operation, with the driver connected to the adder: request 10,20,30,40 -> add_enbl sequence 0,1,2,3,3; rsp_valid 5 cycles after acceptance; rsp_sum=100, rsp_err=0, ops_done=1.
- Wrap-around: request 200,100,0,1 -> rsp_sum=45 (301 mod 256), rsp_err=0.
- Forced mismatch: force add_out to 0 during WAIT for request 1,1,1,1 -> rsp_sum=0, rsp_err=1, err_cnt=1.
- Backpressure and operand stability:
  - hold rsp_ready=0 for 10 cycles -> rsp_valid and rsp_sum stable, req_ready=0, add_enbl=3 throughout;
  - req_valid asserted with new operands while busy -> not accepted.
- Reset mid-operation: assert rst=0 during PH1 -> all outputs 0, add_enbl=3 immediately. After release, request 5,5,5,5 -> rsp_sum=20, ops_done=1.
- Back-to-back and counter wrap:
  - three consecutive requests with rsp_ready=1 -> each response follows 5 cycles after its acceptance, ops_done=3;
  - with CNT_W=2, a fifth response -> ops_done wraps to 1.
